// File: rtl/bus_pkg.sv
// Shared bus field map, arbiter state encoding and small helpers.
// The DMA and the other bus masters import this package as well.
package bus_pkg;

    localparam int BUS_W        = 64;
    localparam int OWN_W        = 3;

    localparam int BUS_DATA_LO  = 0;
    localparam int BUS_DATA_HI  = 31;
    localparam int BUS_ADDR_LO  = 32;
    localparam int BUS_ADDR_HI  = 46;
    localparam int BUS_SIZE_LO  = 47;
    localparam int BUS_SIZE_HI  = 49;
    localparam int BUS_START    = 50;
    localparam int BUS_FIRST    = 51;
    localparam int BUS_CACHE    = 52;
    localparam int BUS_RDWR_LO  = 53;
    localparam int BUS_RDWR_HI  = 54;
    localparam int BUS_DST_LO   = 55;
    localparam int BUS_DST_HI   = 56;
    localparam int BUS_SRC_LO   = 57;
    localparam int BUS_SRC_HI   = 58;
    localparam int BUS_VLD      = 59;
    localparam int BUS_REQC_LO  = 60;
    localparam int BUS_REQC_HI  = 62;
    localparam int BUS_INTR     = 63;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Next master index after idx, wrapping at n so the result stays below n.
    function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] idx, input int n);
        int s;
        s = int'(idx) + 1;
        if (s >= n) s = 0;
        return OWN_W'(s);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N; returns a one-hot grant, its index and an any-request flag.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [OWN_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [OWN_W-1:0] idx,
    output logic             any
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = OWN_W'(c);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: interrupt-first round-robin selection, bus lock for a
// whole multi-beat transaction, idle timeout, and one registered output stage.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int          NM       = 4,
    parameter logic [31:0] LOCK_TMO = 32'd64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM-1:0]       i_vld,
    input  logic [BUS_W*NM-1:0] i_bus,
    output logic [NM-1:0]       bus_gnt,
    input  logic                i_busy,
    output logic                o_vld,
    output logic [BUS_W-1:0]    o_bus,
    output logic [OWN_W-1:0]    o_owner,
    output logic                o_tmo
);

    arb_state_e       state, state_nxt;
    logic [OWN_W-1:0] owner, rr_ptr;
    logic [2:0]       beat_cnt;
    logic [31:0]      idle_cnt;
    logic             gap;

    logic [BUS_W-1:0] words [NM];
    logic [NM-1:0]    first, intr, cand, icand, c_gnt, i_gnt, sel_oh;
    logic [OWN_W-1:0] c_idx, i_idx, sel_idx;
    logic             c_any, i_any, sel_vld, take, accept;
    logic             last_beat, tmo_fire, single_done, done;
    logic [BUS_W-1:0] sel_word;
    logic [2:0]       sel_reqc;

    for (genvar g = 0; g < NM; g++) begin : g_split
        assign words[g] = i_bus[g*BUS_W +: BUS_W];
        assign first[g] = words[g][BUS_FIRST];
        assign intr[g]  = words[g][BUS_INTR];
    end

    assign cand  = i_vld & first;
    assign icand = cand & intr;

    rr_pick #(.N(NM)) u_pick_intr (
        .req (icand),
        .ptr (rr_ptr),
        .gnt (i_gnt),
        .idx (i_idx),
        .any (i_any)
    );

    rr_pick #(.N(NM)) u_pick_all (
        .req (cand),
        .ptr (rr_ptr),
        .gnt (c_gnt),
        .idx (c_idx),
        .any (c_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // The cycle right after a transaction ends never accepts, giving the
    // one idle cycle between transactions; reset also blocks every grant.
    always_comb begin
        sel_oh   = '0;
        sel_idx  = owner;
        sel_vld  = 1'b0;
        sel_word = '0;
        if (state == ST_IDLE) begin
            sel_oh  = i_any ? i_gnt : c_gnt;
            sel_idx = i_any ? i_idx : c_idx;
            sel_vld = c_any & ~gap;
        end else begin
            for (int m = 0; m < NM; m++) sel_oh[m] = (owner == OWN_W'(m));
            sel_vld = |(sel_oh & i_vld);
        end
        for (int m = 0; m < NM; m++) begin
            if (sel_oh[m]) sel_word = words[m];
        end
        take    = ~o_vld | ~i_busy;
        accept  = take & sel_vld & rst;
        bus_gnt = ~(sel_oh & {NM{accept}});
    end

    assign sel_reqc = sel_word[BUS_REQC_HI:BUS_REQC_LO];

    always_comb begin
        state_nxt   = state;
        last_beat   = 1'b0;
        tmo_fire    = 1'b0;
        single_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_reqc != 3'd0) state_nxt = ST_LOCK;
                    else                  single_done = 1'b1;
                end
            end
            ST_LOCK: begin
                if (accept && beat_cnt == 3'd1) begin
                    state_nxt = ST_IDLE;
                    last_beat = 1'b1;
                end else if (!sel_vld && (idle_cnt + 32'd1) >= LOCK_TMO) begin
                    state_nxt = ST_IDLE;
                    tmo_fire  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign done = last_beat | tmo_fire | single_done;

    // beat_cnt holds beats still owed after the current one; reqCycles of
    // later beats is deliberately ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_vld    <= 1'b0;
            o_bus    <= '0;
            o_tmo    <= 1'b0;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            gap      <= 1'b0;
        end else begin
            o_tmo <= tmo_fire;
            gap   <= done;
            if (accept) begin
                o_bus <= sel_word;
                o_vld <= 1'b1;
            end else if (!i_busy) begin
                o_vld <= 1'b0;
            end
            if (state == ST_IDLE) begin
                if (accept) begin
                    owner    <= sel_idx;
                    beat_cnt <= sel_reqc;
                    idle_cnt <= '0;
                end
            end else begin
                if (sel_vld || tmo_fire) idle_cnt <= '0;
                else                     idle_cnt <= idle_cnt + 32'd1;
                if (accept) beat_cnt <= beat_cnt - 3'd1;
            end
            if (done) rr_ptr <= wrap_inc(sel_idx, NM);
        end
    end

    assign o_owner = owner;

endmodule
